// File: rtl/rv_mem_pkg.sv
// Shared load/store encodings, FSM states and request metadata for the data-memory path.
// Pure declarations; no timing or flow control of its own.
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } lsu_state_t;

    typedef struct packed {
        logic       we;
        logic [2:0] funct3;
        logic [1:0] off;
    } req_meta_t;

    // Reserved funct3 codes are treated as misaligned so they never reach memory.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (funct3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = off[0];
            F3_W:        bad = (off != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half from a read word and sign- or zero-extends it.
// Combinational, zero latency; no flow control.
module load_align
    import rv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[7:0];
        case (off)
            2'd0: byte_v = rdata[7:0];
            2'd1: byte_v = rdata[15:8];
            2'd2: byte_v = rdata[23:16];
            2'd3: byte_v = rdata[31:24];
            default: byte_v = rdata[7:0];
        endcase
        half_v = off[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    result = {{24{byte_v[7]}}, byte_v};
            F3_BU:   result = {24'h0, byte_v};
            F3_H:    result = {{16{half_v[15]}}, half_v};
            F3_HU:   result = {16'h0, half_v};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one request at a time onto a req/gnt + rvalid word port, with timeout.
// Latency accept->resp_valid 3 cycles with no wait states (1 if misaligned); req_ready only in IDLE.
module lsu_ctrl
    import rv_mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_data,
    output logic        busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    req_meta_t        meta_q;
    logic [31:0]      addr_q, wdata_q, resp_data_q;
    logic [3:0]       wstrb_q;
    logic             resp_err_q;

    logic        accept, set_resp, resp_err_n, timeout;
    logic [31:0] resp_data_n, wdata_n, load_val;
    logic [3:0]  wstrb_n;

    load_align u_align (
        .rdata  (mem_rdata),
        .off    (meta_q.off),
        .funct3 (meta_q.funct3),
        .result (load_val)
    );

    // Replicate store data across lanes so the strobe alone selects the target bytes.
    always_comb begin
        wdata_n = req_wdata;
        wstrb_n = 4'b1111;
        case (req_funct3[1:0])
            2'b00: begin
                wdata_n = {4{req_wdata[7:0]}};
                wstrb_n = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                wdata_n = {2{req_wdata[15:0]}};
                wstrb_n = 4'b0011 << req_addr[1:0];
            end
            default: begin
                wdata_n = req_wdata;
                wstrb_n = 4'b1111;
            end
        endcase
        if (!req_we) begin
            wdata_n = 32'h0;
            wstrb_n = 4'b0000;
        end
    end

    assign timeout = (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        set_resp    = 1'b0;
        resp_err_n  = 1'b0;
        resp_data_n = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (is_misaligned(req_funct3, req_addr[1:0])) begin
                        state_d    = S_RESP;
                        set_resp   = 1'b1;
                        resp_err_n = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (timeout) begin
                    state_d    = S_RESP;
                    set_resp   = 1'b1;
                    resp_err_n = 1'b1;
                end else if (mem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response arriving on the last counted cycle still completes normally.
                if (mem_rvalid) begin
                    state_d     = S_RESP;
                    set_resp    = 1'b1;
                    resp_data_n = meta_q.we ? 32'h0 : load_val;
                end else if (timeout) begin
                    state_d    = S_RESP;
                    set_resp   = 1'b1;
                    resp_err_n = 1'b1;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            meta_q      <= '0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            resp_err_q  <= 1'b0;
            resp_data_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q       <= '0;
                meta_q.we     <= req_we;
                meta_q.funct3 <= req_funct3;
                meta_q.off    <= req_addr[1:0];
                addr_q      <= {req_addr[31:2], 2'b00};
                wdata_q     <= wdata_n;
                wstrb_q     <= wstrb_n;
            end else if (state_q == S_REQ || state_q == S_WAIT) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (set_resp) begin
                resp_err_q  <= resp_err_n;
                resp_data_q <= resp_data_n;
            end
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign mem_req    = (state_q == S_REQ);
    assign mem_we     = (state_q == S_REQ) && meta_q.we;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wstrb  = wstrb_q;
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = resp_err_q;
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scenario-per-task bench for lsu_ctrl with a response scoreboard queue and a small memory responder.
module tb_lsu_ctrl;
    import rv_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        resp_valid, resp_err, busy;
    logic [31:0] resp_data;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_data(resp_data),
        .busy(busy)
    );

    typedef struct packed {
        logic [7:0]  cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // Observations filled in by issue()
    int          o_cyc, o_reqs;
    logic        o_err, o_we, o_stable, o_rdy;
    logic [31:0] o_data, o_addr, o_wdata;
    logic [3:0]  o_strb;

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                         input logic [31:0] rdata);
        int   reqc, gcyc;
        logic granted;
        @(negedge clk);
        o_rdy      = req_ready;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(negedge clk);
        req_valid = 1'b0;
        o_cyc = -1; o_err = 1'bx; o_data = 'x; o_stable = 1'b1;
        o_addr = 32'h0; o_wdata = 32'h0; o_strb = 4'h0; o_we = 1'b0;
        reqc = 0; gcyc = 0; granted = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (resp_valid) begin
                o_cyc = n; o_err = resp_err; o_data = resp_data;
                break;
            end
            if (mem_req) begin
                if (reqc == 0) begin
                    o_addr = mem_addr; o_wdata = mem_wdata; o_strb = mem_wstrb; o_we = mem_we;
                end else if ({mem_addr, mem_wdata, mem_wstrb, mem_we} !== {o_addr, o_wdata, o_strb, o_we}) begin
                    o_stable = 1'b0;
                end
                if (reqc == gnt_dly) begin
                    mem_gnt = 1'b1; granted = 1'b1; gcyc = n;
                end
                reqc++;
            end else if (granted && (n - gcyc - 1) == rv_dly) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
            end
            @(negedge clk);
        end
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        o_reqs = reqc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !== {1'b0, 1'b0, 32'h0, 32'h0, 4'h0}) begin
            errors++;
            $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h strb=%b, want all zero",
                     mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb);
        end
        checks++;
        if ({resp_valid, resp_err, resp_data, busy, req_ready} !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_core: got valid=%b err=%b data=%h busy=%b ready=%b, want 0 0 0 0 1",
                     resp_valid, resp_err, resp_data, busy, req_ready);
        end
        reset = 1'b0;
    endtask

    task automatic test_loads();
        logic [31:0] t_addr[6]  = '{32'h103, 32'h102, 32'h202, 32'h202, 32'h100, 32'h504};
        logic [2:0]  t_f3[6]    = '{F3_B, F3_BU, F3_HU, F3_H, F3_H, F3_W};
        logic [31:0] t_rdata[6] = '{32'h80FF_1234, 32'h80FF_1234, 32'h9ABC_0000,
                                    32'h9ABC_0000, 32'h0000_7FFF, 32'hCAFE_F00D};
        logic [31:0] t_exp[6]   = '{32'hFFFF_FF80, 32'h0000_00FF, 32'h0000_9ABC,
                                    32'hFFFF_9ABC, 32'h0000_7FFF, 32'hCAFE_F00D};
        logic [31:0] t_maddr[6] = '{32'h100, 32'h100, 32'h200, 32'h200, 32'h100, 32'h504};
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back('{cyc: 8'd3, err: 1'b0, data: t_exp[i]});
            issue(1'b0, t_f3[i], t_addr[i], 32'h0, 0, 0, t_rdata[i]);
            e = sb_q.pop_front();
            checks++;
            if (o_cyc != int'(e.cyc) || o_err !== e.err || o_data !== e.data) begin
                errors++;
                $display("FAIL load%0d_resp: got cyc=%0d err=%b data=%h, want cyc=%0d err=%b data=%h",
                         i, o_cyc, o_err, o_data, e.cyc, e.err, e.data);
            end
            checks++;
            if (o_addr !== t_maddr[i] || o_we !== 1'b0 || o_strb !== 4'h0 || o_reqs != 1) begin
                errors++;
                $display("FAIL load%0d_mem: got addr=%h we=%b strb=%b reqs=%0d, want addr=%h we=0 strb=0000 reqs=1",
                         i, o_addr, o_we, o_strb, o_reqs, t_maddr[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || resp_data !== 32'hCAFE_F00D || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL resp_hold: got valid=%b err=%b data=%h, want 0 0 cafef00d",
                     resp_valid, resp_err, resp_data);
        end
    endtask

    task automatic test_stores();
        logic [31:0] t_addr[3]  = '{32'h301, 32'h206, 32'h010};
        logic [2:0]  t_f3[3]    = '{F3_B, F3_H, F3_W};
        logic [31:0] t_d[3]     = '{32'h0000_00A5, 32'h1234_BEEF, 32'hDEAD_BEEF};
        int          t_gnt[3]   = '{0, 1, 3};
        int          t_rv[3]    = '{0, 2, 1};
        int          t_cyc[3]   = '{3, 6, 7};
        logic [31:0] t_wdata[3] = '{32'hA5A5_A5A5, 32'hBEEF_BEEF, 32'hDEAD_BEEF};
        logic [3:0]  t_strb[3]  = '{4'b0010, 4'b1100, 4'b1111};
        logic [31:0] t_maddr[3] = '{32'h300, 32'h204, 32'h010};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back('{cyc: 8'(t_cyc[i]), err: 1'b0, data: 32'h0});
            issue(1'b1, t_f3[i], t_addr[i], t_d[i], t_gnt[i], t_rv[i], 32'hFFFF_FFFF);
            e = sb_q.pop_front();
            checks++;
            if (o_cyc != int'(e.cyc) || o_err !== e.err || o_data !== e.data) begin
                errors++;
                $display("FAIL store%0d_resp: got cyc=%0d err=%b data=%h, want cyc=%0d err=%b data=%h",
                         i, o_cyc, o_err, o_data, e.cyc, e.err, e.data);
            end
            checks++;
            if (o_addr !== t_maddr[i] || o_we !== 1'b1 || o_strb !== t_strb[i] ||
                o_wdata !== t_wdata[i] || !o_stable || o_reqs != t_gnt[i] + 1) begin
                errors++;
                $display("FAIL store%0d_mem: got addr=%h we=%b strb=%b wdata=%h stable=%b reqs=%0d, want addr=%h we=1 strb=%b wdata=%h stable=1 reqs=%0d",
                         i, o_addr, o_we, o_strb, o_wdata, o_stable, o_reqs,
                         t_maddr[i], t_strb[i], t_wdata[i], t_gnt[i] + 1);
            end
        end
    endtask

    task automatic test_misaligned();
        logic        t_we[4]   = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0]  t_f3[4]   = '{F3_W, F3_H, 3'b011, F3_HU};
        logic [31:0] t_addr[4] = '{32'h402, 32'h401, 32'h000, 32'h203};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back('{cyc: 8'd1, err: 1'b1, data: 32'h0});
            issue(t_we[i], t_f3[i], t_addr[i], 32'h1111_2222, 0, 0, 32'h5555_5555);
            e = sb_q.pop_front();
            checks++;
            if (o_cyc != int'(e.cyc) || o_err !== e.err || o_data !== e.data || o_reqs != 0) begin
                errors++;
                $display("FAIL misalign%0d: got cyc=%0d err=%b data=%h reqs=%0d, want cyc=%0d err=%b data=%h reqs=0",
                         i, o_cyc, o_err, o_data, o_reqs, e.cyc, e.err, e.data);
            end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        logic quiet;
        sb_q.push_back('{cyc: 8'd9, err: 1'b1, data: 32'h0});
        issue(1'b0, F3_W, 32'h600, 32'h0, 1000, 0, 32'h0);
        e = sb_q.pop_front();
        checks++;
        if (o_cyc != int'(e.cyc) || o_err !== e.err || o_data !== e.data || o_reqs != 8) begin
            errors++;
            $display("FAIL timeout_resp: got cyc=%0d err=%b data=%h reqs=%0d, want cyc=%0d err=%b data=%h reqs=8",
                     o_cyc, o_err, o_data, o_reqs, e.cyc, e.err, e.data);
        end
        quiet = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            mem_rvalid = (k == 2);
            mem_rdata  = 32'h7777_7777;
            if (resp_valid !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        mem_rvalid = 1'b0;
        checks++;
        if (quiet !== 1'b1) begin
            errors++;
            $display("FAIL timeout_stray: got quiet=%b, want 1 (no resp_valid/mem_req/busy after timeout)", quiet);
        end
    endtask

    task automatic test_reset_in_wait();
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h700;
        @(negedge clk);
        req_valid = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        checks++;
        if (busy !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL wait_state: got busy=%b mem_req=%b, want busy=1 mem_req=0", busy, mem_req);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h3333_3333;
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_wait: got busy=%b valid=%b mem_req=%b ready=%b, want 0 0 0 1",
                     busy, resp_valid, mem_req, req_ready);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_stray: got valid=%b busy=%b, want 0 0", resp_valid, busy);
        end
        sb_q.push_back('{cyc: 8'd3, err: 1'b0, data: 32'h1234_5678});
        issue(1'b0, F3_W, 32'h500, 32'h0, 0, 0, 32'h1234_5678);
        e = sb_q.pop_front();
        checks++;
        if (o_cyc != int'(e.cyc) || o_err !== e.err || o_data !== e.data || o_addr !== 32'h500) begin
            errors++;
            $display("FAIL post_reset_lw: got cyc=%0d err=%b data=%h addr=%h, want cyc=%0d err=%b data=%h addr=00000500",
                     o_cyc, o_err, o_data, o_addr, e.cyc, e.err, e.data);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back('{cyc: 8'd3, err: 1'b0, data: 32'hFFFF_8001 + 32'(i)});
        end
        for (int i = 0; i < 2; i++) begin
            issue(1'b0, F3_H, 32'h800, 32'h0, 0, 0, 32'h0000_8001 + 32'(i));
            e = sb_q.pop_front();
            checks++;
            if (o_rdy !== 1'b1 || o_cyc != int'(e.cyc) || o_err !== e.err || o_data !== e.data) begin
                errors++;
                $display("FAIL b2b%0d: got ready=%b cyc=%0d err=%b data=%h, want ready=1 cyc=%0d err=%b data=%h",
                         i, o_rdy, o_cyc, o_err, o_data, e.cyc, e.err, e.data);
            end
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        test_reset();
        test_loads();
        test_stores();
        test_misaligned();
        test_timeout();
        test_reset_in_wait();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Sequences data-memory loads and stores for the core.
- Accepts one request at a time from the execute stage and drives a word-addressed memory port with a req/gnt + rvalid handshake.
- Aligns store data and byte strobes; extracts and sign- or zero-extends load data (lb/lh/lw/lbu/lhu) from the returned word.
- Reports completion, misalignment or timeout back to the core, which stalls while `busy` is high.

Parameters:
- `TIMEOUT`, 255: maximum cycles from request acceptance to `mem_rvalid` before abort. Range 2..65535.
- `CNT_W`, 16: width of the timeout counter.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req_valid` input 1: core presents a request.
- `req_ready` output 1: controller can accept a request (high in IDLE only).
- `req_we` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-justified.
- `mem_req` output 1: memory request.
- `mem_we` output 1: memory write enable.
- `mem_addr` output 32: word-aligned address, low 2 bits are 0.
- `mem_wdata` output 32: lane-shifted store data.
- `mem_wstrb` output 4: byte strobes (0 for loads).
- `mem_gnt` input 1: memory accepted the request.
- `mem_rvalid` input 1: read data valid, or write acknowledge.
- `mem_rdata` input 32: read word.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_err` output 1: qualifies `resp_valid`; 1 = misaligned or timeout.
- `resp_data` output 32: extended load result (0 for stores and errors).
- `busy` output 1: high in any state other than IDLE.

Behaviour:
- **Reset.**
  - State goes to IDLE and the counter is cleared.
  - Outputs after reset: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0, `resp_valid`=0, `resp_err`=0, `resp_data`=0, `busy`=0, `req_ready`=1.
  - Reset takes effect at any point mid-operation. `mem_req` is low from the cycle after the reset edge, and any outstanding `mem_rvalid` is ignored.
- **States:** IDLE, REQ, WAIT, RESP.
- **IDLE.**
  - Accept when `req_valid` is high; `req_ready` is 1 in this state. Register `we`, `funct3`, `addr[1:0]` and the lane-shifted data/strobes.
  - Misalignment check: h/hu with `addr[0]`=1, w with `addr[1:0]`≠0, or `funct3` ∈ {011, 110, 111}. On misalignment go to RESP with err=1 and no memory access.
  - Otherwise go to REQ with the counter cleared.
- **REQ.**
  - `mem_req`=1; all `mem_*` outputs are stable until `mem_gnt`.
  - `mem_gnt`=1 → WAIT. `mem_req` drops the following cycle.
- **WAIT.**
  - `mem_rvalid` is sampled only in WAIT, so the earliest response is the cycle after `mem_gnt`.
  - On `mem_rvalid`, capture and extend `mem_rdata`, then go to RESP with err=0.
- **Timeout.**
  - The counter increments every cycle in REQ or WAIT.
  - When the counter reaches `TIMEOUT`-1 without completion, go to RESP with err=1. This applies even if `mem_req` was never granted.
  - A later stray `mem_rvalid` is ignored.
- **RESP.**
  - `resp_valid`=1 for exactly one cycle, with `resp_err`/`resp_data` valid.
  - Then return to IDLE. `req_ready` is 0 during RESP, so back-to-back requests are accepted one cycle after RESP.
- **Latency (no wait states):** accept at cycle 0, `mem_req` at cycle 1 with `mem_gnt`=1, `mem_rvalid` at cycle 2, `resp_valid` at cycle 3. Misaligned requests: `resp_valid` at cycle 1.
- **Store lanes** (`off` = `addr[1:0]`):
  - sb: `wdata` = {4{`d[7:0]`}}, `wstrb` = 0001<<off.
  - sh: `wdata` = {2{`d[15:0]`}}, `wstrb` = 0011<<off.
  - sw: `wdata` = `d`, `wstrb` = 1111.
- **Load extraction.**
  - byte = `rdata[8*off+7 : 8*off]`; half = `rdata[16*off[1]+15 : 16*off[1]]`.
  - lb/lh are sign-extended from bit 7/15; lbu/lhu are zero-extended; lw passes through.
- **Stores:** completion is on `mem_rvalid` (write ack); `resp_data`=0.
- **Between pulses:** `resp_data`/`resp_err` hold their last value; only `resp_valid` is a pulse.

Decomposition:
- **Shared package `rv_mem_pkg`:**
  - funct3 load/store constants (F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101).
  - FSM state encoding.
  - The `TIMEOUT` default.
- **Sub-module `load_align`:** combinational; inputs `rdata`, `off`, `funct3`; output the 32-bit extended result. Instantiated once in the WAIT capture path.

Test Plan:
- **lb at addr 0x103:** `mem_rdata`=0x80FF_1234 → `mem_addr`=0x100, `resp_data`=0xFFFF_FF80, `resp_err`=0, `resp_valid` 3 cycles after accept.
- **lhu and lh at addr 0x202:** `rdata`=0x9ABC_0000 → lhu gives 0x0000_9ABC; lh gives 0xFFFF_9ABC.
- **sb at addr 0x301, data 0x0000_00A5** → `mem_we`=1, `mem_wstrb`=0010, `mem_wdata`=0xA5A5_A5A5, `resp_data`=0 after ack.
- **Misaligned accesses:** sw at 0x402 → no `mem_req` ever, `resp_valid`/`resp_err`=1 at cycle 1. The same holds for lh at 0x401.
- **Timeout:** `mem_gnt` held 0 with `TIMEOUT`=8 → `resp_err`=1 after 8 counted cycles, `mem_req` low afterward. A stray `mem_rvalid` 2 cycles later produces no `resp_valid`.
- **Stall and reset:**
  - `mem_gnt` delayed 3 cycles → `mem_addr`/`mem_wdata`/`mem_wstrb` stable throughout.
  - `reset` asserted in WAIT → IDLE next cycle, `busy`=0, no `resp_valid`.
  - The next lw at 0x500 completes normally.
